// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: default widths, ALU control codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int CTRL_W_DEF = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; grant is combinational from req/en, prio updates on grant.
// Latency: grant same cycle; prio takes effect on the next contested cycle.
// Backpressure: en low (no accept window) suppresses all grants.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // prio=1 means port 1 wins the next tie
    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = prio ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (|gnt) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between execute (port 0) and branch/address (port 1) requesters.
// Latency: accept at edge N, response valid after edge N+1; one op in flight at a time.
// Backpressure: a response held by rspN_ready=0 stalls the FSM and blocks new accepts.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_zero,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_zero,

    output logic [WIDTH-1:0]  alu_input_1,
    output logic [WIDTH-1:0]  alu_input_2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero
);

    state_t             state_q;
    state_t             state_d;
    logic               tag_q;
    logic [1:0]         rsp_vld_q;
    logic [WIDTH-1:0]   res_q;
    logic               zero_q;

    logic               rsp_rdy_tag;
    logic               rsp_hs;
    logic               accept_win;
    logic [1:0]         gnt;
    logic               accept;

    assign rsp_rdy_tag = tag_q ? rsp1_ready : rsp0_ready;
    assign rsp_hs      = (state_q == RESP) && rsp_rdy_tag;
    // rst_n gating keeps ready low for the whole time reset is held
    assign accept_win  = rst_n && ((state_q == IDLE) || rsp_hs);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1_valid, req0_valid}),
        .en    (accept_win),
        .gnt   (gnt)
    );

    assign accept     = |gnt;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_rdy_tag) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_input_1 <= '0;
            alu_input_2 <= '0;
            alu_ctrl    <= '0;
            tag_q       <= 1'b0;
            rsp_vld_q   <= 2'b00;
            res_q       <= '0;
            zero_q      <= 1'b0;
        end else begin
            if (rsp_hs) begin
                rsp_vld_q <= 2'b00;
            end
            // operands only move on accept so the ALU inputs stay quiet otherwise
            if (accept) begin
                alu_input_1 <= gnt[1] ? req1_a    : req0_a;
                alu_input_2 <= gnt[1] ? req1_b    : req0_b;
                alu_ctrl    <= gnt[1] ? req1_ctrl : req0_ctrl;
                tag_q       <= gnt[1];
            end
            if (state_q == EXEC) begin
                res_q            <= alu_result;
                zero_q           <= alu_zero;
                rsp_vld_q[tag_q] <= 1'b1;
            end
        end
    end

    assign rsp0_valid  = rsp_vld_q[0];
    assign rsp1_valid  = rsp_vld_q[1];
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized bench for alu_share_ctrl against a transaction-level model of the sharing rules.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req_valid [2];
    logic          req_ready [2];
    logic [W-1:0]  req_a     [2];
    logic [W-1:0]  req_b     [2];
    logic [CW-1:0] req_ctrl  [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic [W-1:0]  rsp_result[2];
    logic          rsp_zero  [2];
    logic [W-1:0]  alu_input_1, alu_input_2, alu_result;
    logic [CW-1:0] alu_ctrl;
    logic          alu_zero;

    alu_share_ctrl #(.WIDTH(W), .CTRL_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req_valid[0]),
        .req0_ready  (req_ready[0]),
        .req0_a      (req_a[0]),
        .req0_b      (req_b[0]),
        .req0_ctrl   (req_ctrl[0]),
        .req1_valid  (req_valid[1]),
        .req1_ready  (req_ready[1]),
        .req1_a      (req_a[1]),
        .req1_b      (req_b[1]),
        .req1_ctrl   (req_ctrl[1]),
        .rsp0_valid  (rsp_valid[0]),
        .rsp0_ready  (rsp_ready[0]),
        .rsp0_result (rsp_result[0]),
        .rsp0_zero   (rsp_zero[0]),
        .rsp1_valid  (rsp_valid[1]),
        .rsp1_ready  (rsp_ready[1]),
        .rsp1_result (rsp_result[1]),
        .rsp1_zero   (rsp_zero[1]),
        .alu_input_1 (alu_input_1),
        .alu_input_2 (alu_input_2),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    // Stand-in for the datapath ALU; unknown codes give a ^ b
    function automatic logic [W-1:0] ref_alu(logic [W-1:0] a, logic [W-1:0] b, logic [CW-1:0] c);
        case (c)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_input_1, alu_input_2, alu_ctrl);
    assign alu_zero   = (alu_result == '0);

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: one op in flight, response visible from the 2nd cycle after accept
    bit            inflight;
    int            age;
    int            tag;
    logic [W-1:0]  exp_res;
    logic          exp_zero;
    int            exp_prio;
    logic [W-1:0]  last_a, last_b;
    logic [CW-1:0] last_c;
    bit            acc_seen [2];
    int            acc_cnt;
    int            lit_mode;

    task automatic model_reset();
        inflight = 0; age = 0; tag = 0; exp_prio = 0; acc_cnt = 0;
        exp_res = '0; exp_zero = 1'b0;
        last_a = '0; last_b = '0; last_c = '0;
        acc_seen[0] = 0; acc_seen[1] = 0;
    endtask

    task automatic new_op(int i);
        int r;
        req_a[i] = ($urandom % 2 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
        req_b[i] = ($urandom % 4 == 0) ? req_a[i] : W'($urandom);
        r = $urandom % 8;
        case (r)
            0: req_ctrl[i] = ALU_AND;
            1: req_ctrl[i] = ALU_OR;
            2: req_ctrl[i] = ALU_ADD;
            3: req_ctrl[i] = ALU_SUB;
            4: req_ctrl[i] = ALU_SLT;
            default: req_ctrl[i] = CW'($urandom);
        endcase
    endtask

    task automatic monitor();
        bit hs, acc;
        int win;
        check("one_ready", 64'(req_ready[0] & req_ready[1]), 0);
        check("alu_a", alu_input_1, last_a);
        check("alu_b", alu_input_2, last_b);
        check("alu_ctrl", alu_ctrl, last_c);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rsp%0d_valid", i), 64'(rsp_valid[i]), 64'(inflight && age >= 1 && tag == i));
        end
        if (inflight && age >= 1) begin
            check("rsp_result", rsp_result[tag], exp_res);
            check("rsp_zero", 64'(rsp_zero[tag]), 64'(exp_zero));
        end
        if (lit_mode == 1 && rsp_valid[0]) begin
            check("or_res", rsp_result[0], 3);
            check("or_zero", 64'(rsp_zero[0]), 0);
        end
        if (lit_mode == 1 && rsp_valid[1]) begin
            check("sub_res", rsp_result[1], 0);
            check("sub_zero", 64'(rsp_zero[1]), 1);
        end
        if (lit_mode == 2 && rsp_valid[1]) begin
            check("bp_hold_res", rsp_result[1], 2);
            check("bp_req0_blocked", 64'(req_ready[0]), 0);
        end
        if (lit_mode == 3) check("bp_accept_in_hs", 64'(req_ready[0]), 1);

        hs  = inflight && age >= 1 && rsp_ready[tag];
        acc = (req_valid[0] || req_valid[1]) && (!inflight || hs);
        win = (req_valid[0] && req_valid[1]) ? exp_prio : (req_valid[1] ? 1 : 0);
        check("req0_ready", 64'(req_ready[0]), 64'(acc && win == 0));
        check("req1_ready", 64'(req_ready[1]), 64'(acc && win == 1));

        acc_seen[0] = 0; acc_seen[1] = 0;
        if (hs) inflight = 0;
        if (acc) begin
            inflight = 1; age = 0; tag = win;
            exp_res  = ref_alu(req_a[win], req_b[win], req_ctrl[win]);
            exp_zero = (exp_res == '0);
            last_a = req_a[win]; last_b = req_b[win]; last_c = req_ctrl[win];
            exp_prio = 1 - win;
            acc_seen[win] = 1;
            acc_cnt++;
        end else if (inflight) begin
            age++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // mode 0: hold same ops, 1: random light stall, 2: heavy stall, 3: drain
    task automatic drive(int mode);
        for (int i = 0; i < 2; i++) begin
            if (acc_seen[i]) begin
                if (mode == 3) begin
                    req_valid[i] = 1'b0;
                end else if (mode != 0) begin
                    req_valid[i] = ($urandom % 2) == 1;
                    if (req_valid[i]) new_op(i);
                end
            end else if (!req_valid[i] && (mode == 1 || mode == 2) && ($urandom % 3 != 0)) begin
                req_valid[i] = 1'b1;
                new_op(i);
            end
            case (mode)
                1:       rsp_ready[i] = ($urandom % 4) != 0;
                2:       rsp_ready[i] = ($urandom % 3) == 0;
                default: rsp_ready[i] = 1'b1;
            endcase
        end
    endtask

    initial begin
        lit_mode = 0;
        model_reset();
        rst_n = 1'b0;
        req_valid[0] = 1'b1; req_a[0] = 2; req_b[0] = 1; req_ctrl[0] = ALU_OR;
        req_valid[1] = 1'b1; req_a[1] = 5; req_b[1] = 5; req_ctrl[1] = ALU_SUB;
        rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", 64'(req_ready[0]), 0);
        check("rst_req1_ready", 64'(req_ready[1]), 0);
        check("rst_rsp0_valid", 64'(rsp_valid[0]), 0);
        check("rst_rsp1_valid", 64'(rsp_valid[1]), 0);
        check("rst_alu_a", alu_input_1, 0);
        check("rst_alu_b", alu_input_2, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_result", rsp_result[0], 0);
        check("rst_zero", 64'(rsp_zero[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // contention with fixed ops: strict alternation, one op per 2 cycles
        lit_mode = 1;
        tick();
        repeat (12) begin
            drive(0);
            tick();
        end
        check("throughput", acc_cnt, 7);
        lit_mode = 0;
        repeat (6) begin drive(3); tick(); end

        // back-pressure on port 1 while port 0 waits
        req_valid[1] = 1'b1; req_a[1] = 6; req_b[1] = 3; req_ctrl[1] = ALU_AND;
        rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b0;
        tick();
        req_valid[1] = 1'b0;
        req_valid[0] = 1'b1; req_a[0] = 1; req_b[0] = 4; req_ctrl[0] = ALU_OR;
        tick();
        lit_mode = 2;
        repeat (4) tick();
        rsp_ready[1] = 1'b1;
        lit_mode = 3;
        tick();
        lit_mode = 0;
        repeat (6) begin drive(3); tick(); end

        // undecoded control code passes straight through
        req_valid[0] = 1'b1; req_a[0] = 32'h1234; req_b[0] = 32'h00FF; req_ctrl[0] = 4'b1000;
        rsp_ready[0] = 1'b0;
        tick();
        check("unk_ctrl", alu_ctrl, 4'b1000);
        req_valid[0] = 1'b0;
        tick();
        check("unk_res", rsp_result[0], 32'h12CB);
        check("unk_vld", 64'(rsp_valid[0]), 1);
        rsp_ready[0] = 1'b1;
        repeat (4) begin drive(3); tick(); end

        // reset while the op is in EXEC
        req_valid[0] = 1'b1; req_a[0] = 7; req_b[0] = 8; req_ctrl[0] = ALU_ADD;
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        monitor();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (5) begin
            tick();
            check("midrst_no_rsp", 64'(rsp_valid[0]), 0);
        end
        req_valid[0] = 1'b1; new_op(0);
        req_valid[1] = 1'b1; new_op(1);
        @(negedge clk);
        check("midrst_prio0", 64'(req_ready[0]), 1);
        monitor();
        @(posedge clk);
        #1;

        repeat (600) begin drive(1); tick(); end
        repeat (600) begin drive(2); tick(); end
        repeat (10)  begin drive(3); tick(); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
